// File: rtl/pinball_pkg.sv
// Shared pinball raster types: pixel coordinate width, collision report, detector FSM states.
// The report struct is sized for the largest supported configuration; users zero-extend into it.
package pinball_pkg;

    localparam int PIXEL_W    = 11;
    localparam int MAX_SHAPES = 16;
    localparam int MAX_CW     = 16;
    localparam int MAX_SW     = 4;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACCUM      = 1'b1
    } state_t;

    typedef struct packed {
        logic [MAX_SHAPES-1:0] mask;
        logic [MAX_CW-1:0]     count;
        logic [PIXEL_W-1:0]    x;
        logic [PIXEL_W-1:0]    y;
        logic [MAX_SW-1:0]     shape;
        logic                  overrun;
    } report_t;

endpackage

// File: rtl/collision_detector_if.sv
// Collision report bus from detector (master) to game logic (slave), valid/ready handshake.
// All master outputs are registered; result_ready never reaches an output combinationally.
interface collision_detector_if #(
    parameter int NUM_SHAPES = 4,
    parameter int COUNT_MAX  = 255
);
    import pinball_pkg::*;

    localparam int CW = $clog2(COUNT_MAX + 1);
    localparam int SW = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1;

    logic                  result_valid;
    logic                  result_ready;
    logic [NUM_SHAPES-1:0] hitMask;
    logic [CW-1:0]         hitCount;
    logic [PIXEL_W-1:0]    firstHitX;
    logic [PIXEL_W-1:0]    firstHitY;
    logic [SW-1:0]         firstHitShape;
    logic                  overrun;

    modport master (
        output result_valid, hitMask, hitCount, firstHitX, firstHitY, firstHitShape, overrun,
        input  result_ready
    );

    modport slave (
        input  result_valid, hitMask, hitCount, firstHitX, firstHitY, firstHitShape, overrun,
        output result_ready
    );

endinterface

// File: rtl/overlap_counter.sv
// Saturating per-shape overlap counter; clr restarts the count including this cycle's increment.
// hit is a registered-count compare against the frame threshold, valid in the commit cycle.
module overlap_counter #(
    parameter int COUNT_MAX  = 255,
    parameter int MIN_PIXELS = 2,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          hit
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CW'(1) : '0;
        end else if (inc && (cnt_q != CW'(COUNT_MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = (cnt_q >= CW'(MIN_PIXELS));

endmodule

// File: rtl/collision_detector.sv
// Accumulates ball/obstacle overlap per frame and publishes a report 1 cycle after startOfFrame.
// Report held until result_ready; a newer frame overwrites an unaccepted report and flags overrun.
module collision_detector
    import pinball_pkg::*;
#(
    parameter int NUM_SHAPES = 4,
    parameter int MIN_PIXELS = 2,
    parameter int COUNT_MAX  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic [PIXEL_W-1:0]    pixelX,
    input  logic [PIXEL_W-1:0]    pixelY,
    input  logic                  ballDraw,
    input  logic [NUM_SHAPES-1:0] shapeDraw,
    collision_detector_if.master  res
);

    localparam int CW   = $clog2(COUNT_MAX + 1);
    localparam int SW   = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1;
    localparam int SUMW = CW + 5;

    state_t                state_q, state_d;
    logic [NUM_SHAPES-1:0] overlap;
    logic [NUM_SHAPES-1:0] cnt_inc;
    logic [NUM_SHAPES-1:0] new_mask;
    logic [CW-1:0]         cnt [NUM_SHAPES];
    logic                  accum_en;
    logic                  commit;
    logic                  xfer;

    logic                  first_seen_q, first_seen_d;
    logic [PIXEL_W-1:0]    first_x_q, first_x_d;
    logic [PIXEL_W-1:0]    first_y_q, first_y_d;
    logic [SW-1:0]         first_shape_q, first_shape_d;
    logic [SW-1:0]         low_idx;

    logic [SUMW-1:0]       sum;
    logic [CW-1:0]         sum_clamped;

    report_t               report_q, report_d;
    logic                  valid_q, valid_d;

    // The startOfFrame pixel already belongs to the new frame, even when leaving WAIT_FRAME.
    assign overlap  = shapeDraw & {NUM_SHAPES{ballDraw}};
    assign accum_en = startOfFrame | (state_q == ACCUM);
    assign cnt_inc  = overlap & {NUM_SHAPES{accum_en}};
    assign xfer     = valid_q & res.result_ready;

    for (genvar i = 0; i < NUM_SHAPES; i++) begin : g_cnt
        overlap_counter #(
            .COUNT_MAX  (COUNT_MAX),
            .MIN_PIXELS (MIN_PIXELS),
            .CW         (CW)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (startOfFrame),
            .inc   (cnt_inc[i]),
            .cnt   (cnt[i]),
            .hit   (new_mask[i])
        );
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        if (startOfFrame) begin
            state_d = ACCUM;
            commit  = (state_q == ACCUM) && (new_mask != '0);
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
            if (overlap[i]) low_idx = SW'(i);
        end
    end

    always_comb begin
        first_seen_d  = first_seen_q;
        first_x_d     = first_x_q;
        first_y_d     = first_y_q;
        first_shape_d = first_shape_q;
        if (accum_en && (|overlap) && (startOfFrame || !first_seen_q)) begin
            first_seen_d  = 1'b1;
            first_x_d     = pixelX;
            first_y_d     = pixelY;
            first_shape_d = low_idx;
        end else if (startOfFrame) begin
            first_seen_d  = 1'b0;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_SHAPES; i++) begin
            sum = sum + SUMW'(cnt[i]);
        end
        sum_clamped = (sum > SUMW'(COUNT_MAX)) ? CW'(COUNT_MAX) : sum[CW-1:0];
    end

    always_comb begin
        report_d = report_q;
        valid_d  = valid_q;
        if (commit) begin
            report_d.mask    = MAX_SHAPES'(new_mask);
            report_d.count   = MAX_CW'(sum_clamped);
            report_d.x       = first_x_q;
            report_d.y       = first_y_q;
            report_d.shape   = MAX_SW'(first_shape_q);
            report_d.overrun = valid_q & ~res.result_ready;
            valid_d          = 1'b1;
        end else if (xfer) begin
            report_d.overrun = 1'b0;
            valid_d          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_FRAME;
            first_seen_q  <= 1'b0;
            first_x_q     <= '0;
            first_y_q     <= '0;
            first_shape_q <= '0;
            report_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_seen_q  <= first_seen_d;
            first_x_q     <= first_x_d;
            first_y_q     <= first_y_d;
            first_shape_q <= first_shape_d;
            report_q      <= report_d;
            valid_q       <= valid_d;
        end
    end

    assign res.result_valid  = valid_q;
    assign res.hitMask       = report_q.mask[NUM_SHAPES-1:0];
    assign res.hitCount      = report_q.count[CW-1:0];
    assign res.firstHitX     = report_q.x;
    assign res.firstHitY     = report_q.y;
    assign res.firstHitShape = report_q.shape[SW-1:0];
    assign res.overrun       = report_q.overrun;

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector with default parameters (4 shapes, threshold 2, sat 255).
module tb_collision_detector;

    logic        clk;
    logic        reset;
    logic        sof;
    logic [10:0] px;
    logic [10:0] py;
    logic        ball;
    logic [3:0]  shp;

    int vec;
    int errs;

    collision_detector_if #(.NUM_SHAPES(4), .COUNT_MAX(255)) res_if ();

    collision_detector #(
        .NUM_SHAPES (4),
        .MIN_PIXELS (2),
        .COUNT_MAX  (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .pixelX       (px),
        .pixelY       (py),
        .ballDraw     (ball),
        .shapeDraw    (shp),
        .res          (res_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pixel, clock it, then leave outputs settled for sampling.
    task automatic pix(input logic s, input int x, input int y, input logic b, input logic [3:0] sh);
        sof  = s;
        px   = 11'(x);
        py   = 11'(y);
        ball = b;
        shp  = sh;
        @(posedge clk);
        #1;
        sof  = 1'b0;
        ball = 1'b0;
        shp  = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix(0, 0, 0, 0, 4'b0000);
        pix(0, 0, 0, 0, 4'b0000);
        reset = 1'b0;
        vec++;
        if ({res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.firstHitX,
             res_if.firstHitY, res_if.firstHitShape, res_if.overrun} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got v=%b m=%b c=%0d x=%0d y=%0d s=%0d o=%b want all 0",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.firstHitX,
                     res_if.firstHitY, res_if.firstHitShape, res_if.overrun);
        end
    endtask

    task automatic test_no_ball();
        res_if.result_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pix(1, 0, 0, 0, 4'b1111);
            for (int p = 0; p < 4; p++) pix(0, p, f, 0, 4'b1111);
        end
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if ({res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.overrun} !== '0) begin
            errs++;
            $display("FAIL no_ball got v=%b m=%b c=%0d o=%b want all 0",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.overrun);
        end
    endtask

    task automatic test_basic();
        res_if.result_ready = 1'b1;
        pix(0, 100, 50, 1, 4'b0100);
        pix(0, 101, 50, 1, 4'b0100);
        pix(0, 102, 50, 0, 4'b0100);
        vec++;
        if (res_if.result_valid !== 1'b0) begin
            errs++;
            $display("FAIL basic_premature got valid=%b want 0", res_if.result_valid);
        end
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.hitMask !== 4'b0100 || res_if.hitCount !== 8'd2) begin
            errs++;
            $display("FAIL basic_report got v=%b m=%b c=%0d want v=1 m=0100 c=2",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount);
        end
        vec++;
        if (res_if.firstHitX !== 11'd100 || res_if.firstHitY !== 11'd50 ||
            res_if.firstHitShape !== 2'd2 || res_if.overrun !== 1'b0) begin
            errs++;
            $display("FAIL basic_first got x=%0d y=%0d s=%0d o=%b want x=100 y=50 s=2 o=0",
                     res_if.firstHitX, res_if.firstHitY, res_if.firstHitShape, res_if.overrun);
        end
        pix(0, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b0 || res_if.hitMask !== 4'b0100 || res_if.overrun !== 1'b0) begin
            errs++;
            $display("FAIL basic_after_xfer got v=%b m=%b o=%b want v=0 m=0100 o=0",
                     res_if.result_valid, res_if.hitMask, res_if.overrun);
        end
    endtask

    task automatic test_saturate();
        res_if.result_ready = 1'b1;
        pix(0, 5, 5, 1, 4'b0001);
        for (int p = 0; p < 300; p++) pix(0, 6, 5, 1, 4'b1000);
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.hitMask !== 4'b1000 || res_if.hitCount !== 8'd255) begin
            errs++;
            $display("FAIL sat_report got v=%b m=%b c=%0d want v=1 m=1000 c=255",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount);
        end
        vec++;
        if (res_if.firstHitShape !== 2'd0 || res_if.firstHitX !== 11'd5 || res_if.firstHitY !== 11'd5) begin
            errs++;
            $display("FAIL sat_first got s=%0d x=%0d y=%0d want s=0 x=5 y=5",
                     res_if.firstHitShape, res_if.firstHitX, res_if.firstHitY);
        end
        pix(0, 0, 0, 0, 4'b0000);
    endtask

    task automatic test_same_pixel();
        res_if.result_ready = 1'b1;
        pix(0, 19, 30, 0, 4'b1111);
        pix(0, 20, 30, 1, 4'b1010);
        pix(0, 21, 30, 1, 4'b1010);
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.hitMask !== 4'b1010 || res_if.hitCount !== 8'd4 || res_if.firstHitShape !== 2'd1) begin
            errs++;
            $display("FAIL same_px got m=%b c=%0d s=%0d want m=1010 c=4 s=1",
                     res_if.hitMask, res_if.hitCount, res_if.firstHitShape);
        end
        vec++;
        if (res_if.firstHitX !== 11'd20 || res_if.firstHitY !== 11'd30) begin
            errs++;
            $display("FAIL same_px_xy got x=%0d y=%0d want x=20 y=30", res_if.firstHitX, res_if.firstHitY);
        end
        pix(0, 0, 0, 0, 4'b0000);
    endtask

    task automatic test_overrun();
        res_if.result_ready = 1'b0;
        pix(0, 1, 1, 1, 4'b0001);
        pix(0, 2, 1, 1, 4'b0001);
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.hitMask !== 4'b0001 || res_if.overrun !== 1'b0) begin
            errs++;
            $display("FAIL ovr_first got v=%b m=%b o=%b want v=1 m=0001 o=0",
                     res_if.result_valid, res_if.hitMask, res_if.overrun);
        end
        pix(0, 7, 8, 1, 4'b0100);
        pix(0, 8, 8, 1, 4'b0100);
        pix(0, 9, 8, 1, 4'b0100);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.hitMask !== 4'b0001 || res_if.firstHitX !== 11'd1) begin
            errs++;
            $display("FAIL ovr_hold got v=%b m=%b x=%0d want v=1 m=0001 x=1",
                     res_if.result_valid, res_if.hitMask, res_if.firstHitX);
        end
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.hitMask !== 4'b0100 || res_if.hitCount !== 8'd3 ||
            res_if.firstHitX !== 11'd7 || res_if.firstHitY !== 11'd8 || res_if.overrun !== 1'b1) begin
            errs++;
            $display("FAIL ovr_replace got v=%b m=%b c=%0d x=%0d y=%0d o=%b want v=1 m=0100 c=3 x=7 y=8 o=1",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.firstHitX,
                     res_if.firstHitY, res_if.overrun);
        end
        pix(0, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.overrun !== 1'b1 || res_if.result_valid !== 1'b1) begin
            errs++;
            $display("FAIL ovr_sticky got v=%b o=%b want v=1 o=1", res_if.result_valid, res_if.overrun);
        end
        res_if.result_ready = 1'b1;
        pix(0, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b0 || res_if.overrun !== 1'b0 || res_if.hitMask !== 4'b0100) begin
            errs++;
            $display("FAIL ovr_xfer got v=%b o=%b m=%b want v=0 o=0 m=0100",
                     res_if.result_valid, res_if.overrun, res_if.hitMask);
        end
    endtask

    task automatic test_back_to_back();
        res_if.result_ready = 1'b1;
        pix(1, 3, 4, 1, 4'b0010);
        pix(0, 4, 4, 1, 4'b0010);
        pix(1, 9, 9, 1, 4'b0010);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.hitMask !== 4'b0010 || res_if.hitCount !== 8'd2 ||
            res_if.firstHitX !== 11'd3 || res_if.firstHitY !== 11'd4 || res_if.firstHitShape !== 2'd1) begin
            errs++;
            $display("FAIL b2b_sof_pixel got v=%b m=%b c=%0d x=%0d y=%0d s=%0d want v=1 m=0010 c=2 x=3 y=4 s=1",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.firstHitX,
                     res_if.firstHitY, res_if.firstHitShape);
        end
        res_if.result_ready = 1'b0;
        pix(0, 10, 9, 1, 4'b0010);
        res_if.result_ready = 1'b1;
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.overrun !== 1'b0 ||
            res_if.firstHitX !== 11'd9 || res_if.hitCount !== 8'd2) begin
            errs++;
            $display("FAIL b2b_commit_xfer got v=%b o=%b x=%0d c=%0d want v=1 o=0 x=9 c=2",
                     res_if.result_valid, res_if.overrun, res_if.firstHitX, res_if.hitCount);
        end
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b0) begin
            errs++;
            $display("FAIL b2b_drain got v=%b want 0", res_if.result_valid);
        end
    endtask

    task automatic test_reset_mid();
        res_if.result_ready = 1'b1;
        pix(1, 0, 0, 0, 4'b0000);
        for (int p = 0; p < 5; p++) pix(0, 50 + p, 60, 1, 4'b0001);
        reset = 1'b1;
        pix(0, 55, 60, 1, 4'b0001);
        reset = 1'b0;
        vec++;
        if ({res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.firstHitX,
             res_if.firstHitY, res_if.firstHitShape, res_if.overrun} !== '0) begin
            errs++;
            $display("FAIL rst_mid_outputs got v=%b m=%b c=%0d x=%0d y=%0d s=%0d o=%b want all 0",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.firstHitX,
                     res_if.firstHitY, res_if.firstHitShape, res_if.overrun);
        end
        for (int p = 0; p < 3; p++) pix(0, 40 + p, 61, 1, 4'b1001);
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_ignored got v=%b want 0", res_if.result_valid);
        end
        pix(0, 70, 80, 1, 4'b0100);
        pix(0, 71, 80, 1, 4'b0100);
        pix(1, 0, 0, 0, 4'b0000);
        vec++;
        if (res_if.result_valid !== 1'b1 || res_if.hitMask !== 4'b0100 || res_if.hitCount !== 8'd2 ||
            res_if.firstHitX !== 11'd70 || res_if.firstHitY !== 11'd80 || res_if.firstHitShape !== 2'd2) begin
            errs++;
            $display("FAIL rst_mid_next got v=%b m=%b c=%0d x=%0d y=%0d s=%0d want v=1 m=0100 c=2 x=70 y=80 s=2",
                     res_if.result_valid, res_if.hitMask, res_if.hitCount, res_if.firstHitX,
                     res_if.firstHitY, res_if.firstHitShape);
        end
        pix(0, 0, 0, 0, 4'b0000);
    endtask

    initial begin
        vec   = 0;
        errs  = 0;
        reset = 1'b1;
        sof   = 1'b0;
        px    = '0;
        py    = '0;
        ball  = 1'b0;
        shp   = '0;
        res_if.result_ready = 1'b0;
        #1;
        test_reset();
        test_no_ball();
        test_basic();
        test_saturate();
        test_same_pixel();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
